// File: rtl/fuzzy_risk_engine.sv
// Purpose : Mamdani flood-risk estimator; 3 triangular sets per input, 3 rules, weighted-average defuzz.
// Latency : accept at T -> out_valid at T+2 (no rule fired) or T+2+DW (sequential DW-cycle divide).
// Backpres: in_ready only when idle and en=1; result held with out_valid until out_ready.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   en                gates acceptance of new samples only (never aborts an operation)
//   in_valid/in_ready sample handshake for raw (rainfall) and sow (soil moisture), DW bits each
//   out_valid/out_ready result handshake for risk (DW bits) and no_fire (den==0, risk forced 0)
//   busy              engine not idle
module fuzzy_risk_engine #(
    parameter int DW       = 8,
    parameter int A_LO     = 0,
    parameter int B_LO     = 20,
    parameter int C_LO     = 40,
    parameter int A_MD     = 30,
    parameter int B_MD     = 50,
    parameter int C_MD     = 70,
    parameter int A_HI     = 60,
    parameter int B_HI     = 80,
    parameter int C_HI     = 100,
    parameter int R_LO     = 85,
    parameter int R_MD     = 170,
    parameter int R_HI     = 255,
    parameter int AND_MODE = 0,
    parameter int SHOULDER = 0,
    parameter int ROUND    = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] raw,
    input  logic [DW-1:0] sow,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] risk,
    output logic          no_fire,
    output logic          busy
);

    localparam int MAX  = (1 << DW) - 1;
    localparam int NW   = 2 * DW + 2;        // weighted-sum numerator
    localparam int DVW  = 2 * DW + 3;        // numerator plus rounding bias
    localparam int DENW = DW + 2;            // sum of three weights
    localparam int RW   = DW + 3;            // partial remainder (upper dividend slice)
    localparam int TW   = RW + 1;            // trial remainder after shifting in one bit
    localparam int CW   = $clog2(DW) + 1;

    localparam logic [DW-1:0] R_LO_V = DW'(R_LO);
    localparam logic [DW-1:0] R_MD_V = DW'(R_MD);
    localparam logic [DW-1:0] R_HI_V = DW'(R_HI);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FUZZ,
        S_DIV,
        S_DONE
    } state_t;

    state_t          state;
    logic [DW-1:0]   raw_q;
    logic [DW-1:0]   sow_q;
    logic [NW-1:0]   num_r;
    logic [DENW-1:0] den_r;
    logic [RW-1:0]   rem;
    logic [DW-1:0]   lo;
    logic [DW-1:0]   quo;
    logic [CW-1:0]   cnt;

    // Triangular membership with constant breakpoints; the divisors are
    // elaboration-time constants, so each call folds to constant-divide logic.
    // sh_lo/sh_hi turn the left/right half of the set into a flat shoulder.
    function automatic logic [DW-1:0] mu_tri(input logic [DW-1:0] v, input int a, input int b,
                                             input int c, input bit sh_lo, input bit sh_hi);
        int vi;
        int r;
        vi = int'(v);
        if (sh_lo && vi <= b)       r = MAX;
        else if (sh_hi && vi >= b)  r = MAX;
        else if (vi <= a)           r = 0;
        else if (vi <= b)           r = ((vi - a) * MAX) / (b - a);
        else if (vi <= c)           r = ((c - vi) * MAX) / (c - b);
        else                        r = 0;
        return DW'(r);
    endfunction

    function automatic logic [DW-1:0] f_and(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [2*DW-1:0] p;
        p = (2 * DW)'(x) * (2 * DW)'(y);
        if (AND_MODE != 0) return DW'(p >> DW);
        else               return (x < y) ? x : y;
    endfunction

    // ---- fuzzification and rule firing (evaluated during FUZZ) ----
    logic [DW-1:0]   w_lo, w_md, w_hi;
    logic [NW-1:0]   num_c;
    logic [DENW-1:0] den_c;

    assign w_lo = f_and(mu_tri(raw_q, A_LO, B_LO, C_LO, SHOULDER != 0, 1'b0),
                        mu_tri(sow_q, A_LO, B_LO, C_LO, SHOULDER != 0, 1'b0));
    assign w_md = f_and(mu_tri(raw_q, A_MD, B_MD, C_MD, 1'b0, 1'b0),
                        mu_tri(sow_q, A_MD, B_MD, C_MD, 1'b0, 1'b0));
    assign w_hi = f_and(mu_tri(raw_q, A_HI, B_HI, C_HI, 1'b0, SHOULDER != 0),
                        mu_tri(sow_q, A_HI, B_HI, C_HI, 1'b0, SHOULDER != 0));

    assign num_c = NW'(w_lo) * NW'(R_LO_V) + NW'(w_md) * NW'(R_MD_V) + NW'(w_hi) * NW'(R_HI_V);
    assign den_c = DENW'(w_lo) + DENW'(w_md) + DENW'(w_hi);

    // ---- restoring divider ----
    // The quotient is bounded by the largest consequent, so num < den<<DW and
    // the upper dividend slice already starts below den: only DW steps needed.
    logic [DVW-1:0] rnd_add;
    logic [DVW-1:0] dividend;
    logic           first;
    logic           last;
    logic [RW-1:0]  rem_src;
    logic [DW-1:0]  lo_src;
    logic [TW-1:0]  trial;
    logic           ge;
    logic [RW-1:0]  rem_nx;
    logic [DW-1:0]  lo_nx;
    logic [DW-1:0]  q_nx;

    assign rnd_add  = (ROUND != 0) ? DVW'(den_r >> 1) : '0;
    assign dividend = DVW'(num_r) + rnd_add;
    assign first    = (cnt == '0);
    assign last     = (cnt == CW'(DW - 1));
    // First step pulls straight from the registered numerator; later steps
    // continue from the running remainder and the shifting low half.
    assign rem_src  = first ? dividend[DVW-1:DW] : rem;
    assign lo_src   = first ? dividend[DW-1:0]   : lo;
    assign trial    = {rem_src, lo_src[DW-1]};
    assign ge       = (trial >= TW'(den_r));
    assign rem_nx   = ge ? RW'(trial - TW'(den_r)) : RW'(trial);
    assign lo_nx    = DW'({lo_src, 1'b0});
    assign q_nx     = DW'({quo, ge});

    assign in_ready = (state == S_IDLE) && en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            raw_q     <= '0;
            sow_q     <= '0;
            num_r     <= '0;
            den_r     <= '0;
            rem       <= '0;
            lo        <= '0;
            quo       <= '0;
            cnt       <= '0;
            risk      <= '0;
            no_fire   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && en) begin
                        raw_q <= raw;
                        sow_q <= sow;
                        busy  <= 1'b1;
                        state <= S_FUZZ;
                    end
                end
                S_FUZZ: begin
                    num_r <= num_c;
                    den_r <= den_c;
                    quo   <= '0;
                    cnt   <= '0;
                    if (den_c == '0) begin
                        // nothing fired: skip the divider entirely
                        risk      <= '0;
                        no_fire   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        state <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem <= rem_nx;
                    lo  <= lo_nx;
                    quo <= q_nx;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        risk      <= q_nx;
                        no_fire   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fuzzy_risk_engine.sv
// Purpose : randomized + directed check of fuzzy_risk_engine against an arithmetic reference model.
// Latency : checks T+2 / T+10 result timing (DW=8).
// Backpres: exercises out_ready stalls, ignored in_valid pulses, en gating and mid-divide reset.
module tb_fuzzy_risk_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, in_valid, out_ready;
    logic [7:0] raw, sow;
    logic       in_ready, out_valid, no_fire, busy;
    logic [7:0] risk;

    // second instance: product AND, shoulders, rounding
    logic       a_in_valid, a_out_ready;
    logic [7:0] a_raw, a_sow;
    logic       a_in_ready, a_out_valid, a_no_fire, a_busy;
    logic [7:0] a_risk;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fuzzy_risk_engine dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .raw(raw), .sow(sow), .out_valid(out_valid), .out_ready(out_ready),
        .risk(risk), .no_fire(no_fire), .busy(busy)
    );

    fuzzy_risk_engine #(.AND_MODE(1), .SHOULDER(1), .ROUND(1)) dut_alt (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .raw(a_raw), .sow(a_sow), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .risk(a_risk), .no_fire(a_no_fire), .busy(a_busy)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // ---- reference model: straight from the set/rule definitions ----
    function automatic int m_mu(int v, int a, int b, int c, bit sl, bit sh);
        if (sl && v <= b) return 255;
        if (sh && v >= b) return 255;
        if (v <= a) return 0;
        if (v <= b) return (v - a) * 255 / (b - a);
        if (v <= c) return (c - v) * 255 / (c - b);
        return 0;
    endfunction

    function automatic int m_and(int x, int y, bit prod);
        if (prod) return (x * y) / 256;
        return (x < y) ? x : y;
    endfunction

    task automatic model(input int r, input int s, input bit prod, input bit shl, input bit rnd,
                         output int risk_e, output bit nf_e);
        int wl, wm, wh, num, den;
        wl  = m_and(m_mu(r, 0, 20, 40, shl, 0),   m_mu(s, 0, 20, 40, shl, 0),   prod);
        wm  = m_and(m_mu(r, 30, 50, 70, 0, 0),    m_mu(s, 30, 50, 70, 0, 0),    prod);
        wh  = m_and(m_mu(r, 60, 80, 100, 0, shl), m_mu(s, 60, 80, 100, 0, shl), prod);
        num = wl * 85 + wm * 170 + wh * 255;
        den = wl + wm + wh;
        if (den == 0) begin
            risk_e = 0;
            nf_e   = 1'b1;
        end else begin
            risk_e = rnd ? (num + den / 2) / den : num / den;
            nf_e   = 1'b0;
        end
    endtask

    // one transaction on the default instance; 'hold' cycles of out_ready=0
    // in DONE, with in_valid asserted throughout to prove it is ignored
    task automatic run_main(input int r, input int s, input int hold);
        int lat, risk_e, held;
        bit nf_e;
        model(r, s, 0, 0, 0, risk_e, nf_e);
        @(negedge clk);
        raw = 8'(r); sow = 8'(s); in_valid = 1'b1;
        chk("in_ready_idle", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; raw = 8'($urandom); sow = 8'($urandom);
        @(negedge clk);
        lat = 1;
        chk("busy_run", busy, 1);
        chk("in_ready_busy", in_ready, 0);
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, nf_e ? 2 : 10);
        chk("risk", risk, risk_e);
        chk("no_fire", no_fire, int'(nf_e));
        held = risk;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_risk", risk, held);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_drop", out_valid, 0);
        chk("busy_drop", busy, 0);
        chk("risk_kept", risk, held);
    endtask

    task automatic run_alt(input int r, input int s);
        int lat, risk_e;
        bit nf_e;
        model(r, s, 1, 1, 1, risk_e, nf_e);
        @(negedge clk);
        a_raw = 8'(r); a_sow = 8'(s); a_in_valid = 1'b1;
        chk("alt_in_ready", a_in_ready, 1);
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        @(negedge clk);
        lat = 1;
        while (!a_out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("alt_latency", lat, nf_e ? 2 : 10);
        chk("alt_risk", a_risk, risk_e);
        chk("alt_no_fire", a_no_fire, int'(nf_e));
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        chk("alt_valid_drop", a_out_valid, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r, s;
        rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0; raw = '0; sow = '0;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_raw = '0; a_sow = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_risk", risk, 0);
        chk("rst_no_fire", no_fire, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);

        // directed points with hand-derived results
        run_main(20, 20, 0);   chk("spec_20_20", risk, 85);
        run_main(35, 35, 2);   chk("spec_35_35", risk, 127);
        run_main(80, 80, 0);   chk("spec_80_80", risk, 255);
        run_main(50, 50, 1);   chk("spec_50_50", risk, 170);
        run_main(20, 80, 0);   chk("spec_20_80_nf", no_fire, 1);
        run_main(200, 200, 5); chk("spec_200_nf", no_fire, 1);
        chk("spec_200_risk", risk, 0);
        run_alt(35, 35);       chk("alt_round_35", a_risk, 128);
        run_alt(200, 200);     chk("alt_shoulder_200", a_risk, 255);
        run_alt(0, 0);         chk("alt_shoulder_0", a_risk, 85);

        // en=0: no acceptance even with in_valid held
        @(negedge clk);
        en = 1'b0; in_valid = 1'b1; raw = 8'd50; sow = 8'd50;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("en0_in_ready", in_ready, 0);
            chk("en0_busy", busy, 0);
        end
        in_valid = 1'b0; en = 1'b1;
        @(negedge clk);
        chk("en1_in_ready", in_ready, 1);

        // reset in DIV cycle 4 discards the result
        run_main(50, 50, 0);
        @(negedge clk);
        raw = 8'd80; sow = 8'd80; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);                 // FUZZ
        repeat (4) @(negedge clk);      // DIV cycle 4
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_risk", risk, 0);
        chk("midrst_no_fire", no_fire, 0);
        rst_n = 1'b1;
        @(negedge clk);
        repeat (4) @(negedge clk);
        chk("midrst_no_result", out_valid, 0);
        run_main(80, 80, 0);

        // randomized traffic
        for (int k = 0; k < 50; k++) begin
            r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 110));
            s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 110));
            run_main(r, s, int'($urandom_range(0, 2)));
        end
        for (int k = 0; k < 30; k++) begin
            r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 110));
            s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 110));
            run_alt(r, s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
